// File: rtl/ex_muldiv_unit.sv
// ============================================================================
// Module   : ex_muldiv_unit
// Brief    : Iterative radix-2 multiply/divide unit with HI/LO registers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int STEPS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [2:0]       op_in,
  input  logic             mt_lo_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             abort_in,
  output logic             stall_out,
  output logic [WIDTH-1:0] result_out,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             done_out
);

  localparam int         c_CNT_W   = $clog2(STEPS + 1);
  localparam logic [2:0] c_OP_MULT  = 3'd1;
  localparam logic [2:0] c_OP_MULTU = 3'd2;
  localparam logic [2:0] c_OP_DIV   = 3'd3;
  localparam logic [2:0] c_OP_DIVU  = 3'd4;
  localparam logic [2:0] c_OP_MFHI  = 3'd5;
  localparam logic [2:0] c_OP_MFLO  = 3'd6;
  localparam logic [2:0] c_OP_MT    = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_opb;
  logic [WIDTH-1:0]     r_orig_a;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_is_div;
  logic                 r_div0;
  logic                 r_neg_lo;
  logic                 r_neg_hi;

  logic                 w_is_muldiv;
  logic                 w_is_div_op;
  logic                 w_signed;
  logic                 w_start;
  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [WIDTH-1:0]     w_addend;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_mul_next;
  logic [WIDTH:0]       w_rem_sh;
  logic [WIDTH:0]       w_diff;
  logic                 w_qbit;
  logic [2*WIDTH-1:0]   w_div_next;
  logic [2*WIDTH-1:0]   w_prod_fix;
  logic [WIDTH-1:0]     w_q_fix;
  logic [WIDTH-1:0]     w_r_fix;
  logic [WIDTH-1:0]     w_hi_new;
  logic [WIDTH-1:0]     w_lo_new;

  assign w_is_muldiv = (op_in == c_OP_MULT) || (op_in == c_OP_MULTU) ||
                       (op_in == c_OP_DIV)  || (op_in == c_OP_DIVU);
  assign w_is_div_op = (op_in == c_OP_DIV) || (op_in == c_OP_DIVU);
  assign w_signed    = (op_in == c_OP_MULT) || (op_in == c_OP_DIV);
  // A flush or an active reset must keep an issuing op from ever starting.
  assign w_start     = rst_n & valid_in & w_is_muldiv & ~abort_in & (r_state == S_IDLE);

  assign w_a_neg = w_signed & a_in[WIDTH-1];
  assign w_b_neg = w_signed & b_in[WIDTH-1];
  assign w_a_mag = w_a_neg ? -a_in : a_in;
  assign w_b_mag = w_b_neg ? -b_in : b_in;

  // Multiply step: conditional add into the upper half, then shift right.
  assign w_addend   = r_acc[0] ? r_opb : '0;
  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
  assign w_mul_next = {w_sum, r_acc[WIDTH-1:1]};

  // Divide step: upper half is the partial remainder, lower half shifts the
  // dividend out and the quotient bits in.
  assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_opb};
  assign w_qbit     = ~w_diff[WIDTH];
  assign w_div_next = {(w_qbit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]),
                       r_acc[WIDTH-2:0], w_qbit};

  assign w_prod_fix = r_neg_lo ? -r_acc : r_acc;
  assign w_q_fix    = r_neg_lo ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_r_fix    = r_neg_hi ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_comb begin
    w_hi_new = w_prod_fix[2*WIDTH-1:WIDTH];
    w_lo_new = w_prod_fix[WIDTH-1:0];
    if (r_is_div) begin
      if (r_div0) begin
        w_hi_new = r_orig_a;
        w_lo_new = '1;
      end else begin
        w_hi_new = w_r_fix;
        w_lo_new = w_q_fix;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    stall_out = 1'b0;
    done_out  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_next    = S_CALC;
          stall_out = 1'b1;
        end
      end
      S_CALC: begin
        stall_out = 1'b1;
        if (abort_in)                          w_next = S_IDLE;
        else if (r_cnt == c_CNT_W'(1))         w_next = S_FIX;
      end
      S_FIX: begin
        stall_out = 1'b1;
        w_next    = S_IDLE;
        done_out  = ~abort_in;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_acc    <= '0;
      r_opb    <= '0;
      r_orig_a <= '0;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_div0   <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
    end else begin
      if (w_start) begin
        r_acc    <= {{WIDTH{1'b0}}, (w_is_div_op ? w_a_mag : w_b_mag)};
        r_opb    <= w_is_div_op ? w_b_mag : w_a_mag;
        r_orig_a <= a_in;
        r_cnt    <= c_CNT_W'(STEPS);
        r_is_div <= w_is_div_op;
        r_div0   <= (b_in == '0);
        r_neg_lo <= w_a_neg ^ w_b_neg;
        r_neg_hi <= w_a_neg;
      end else if (r_state == S_CALC) begin
        r_acc <= r_is_div ? w_div_next : w_mul_next;
        r_cnt <= r_cnt - c_CNT_W'(1);
      end

      if (r_state == S_FIX && !abort_in) begin
        r_hi <= w_hi_new;
        r_lo <= w_lo_new;
      end else if (r_state == S_IDLE && valid_in && !abort_in && op_in == c_OP_MT) begin
        if (mt_lo_in) r_lo <= a_in;
        else          r_hi <= a_in;
      end
    end
  end

  always_comb begin
    result_out = '0;
    if (valid_in && op_in == c_OP_MFHI)      result_out = r_hi;
    else if (valid_in && op_in == c_OP_MFLO) result_out = r_lo;
  end

  assign hi_out = r_hi;
  assign lo_out = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
// ============================================================================
// Module   : tb_ex_muldiv_unit
// Brief    : Directed self-checking bench for ex_muldiv_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [2:0]  op_in;
  logic        mt_lo_in;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        abort_in;
  logic        stall_out;
  logic [31:0] result_out;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        done_out;

  int errors = 0;
  int checks = 0;

  ex_muldiv_unit #(.WIDTH(32), .STEPS(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .op_in     (op_in),
    .mt_lo_in  (mt_lo_in),
    .a_in      (a_in),
    .b_in      (b_in),
    .abort_in  (abort_in),
    .stall_out (stall_out),
    .result_out(result_out),
    .hi_out    (hi_out),
    .lo_out    (lo_out),
    .done_out  (done_out)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds the instruction in EX for the stalled window, then releases it.
  // With mf_during set, an MFHI waits behind the busy operation.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input bit mf_during, input string tag);
    int nstall;
    int ndone;
    int donek;
    nstall = 0;
    ndone  = 0;
    donek  = -1;
    valid_in = 1'b1;
    op_in    = op;
    a_in     = a;
    b_in     = b;
    for (int k = 0; k < 34; k++) begin
      #1;
      if (stall_out === 1'b1) nstall++;
      if (done_out === 1'b1) begin
        ndone++;
        donek = k;
      end
      step();
      a_in = $urandom;
      b_in = $urandom;
      if (mf_during) op_in = 3'd5;
    end
    if (!mf_during) begin
      valid_in = 1'b0;
      op_in    = 3'd0;
    end
    #1;
    chk({tag, "_stall_end"}, {63'd0, stall_out}, 64'd0);
    chk({tag, "_stall_cycles"}, 64'(nstall), 64'd34);
    chk({tag, "_done_count"}, 64'(ndone), 64'd1);
    chk({tag, "_done_cycle"}, 64'(donek), 64'd33);
    chk({tag, "_hi"}, {32'd0, hi_out}, {32'd0, exp_hi});
    chk({tag, "_lo"}, {32'd0, lo_out}, {32'd0, exp_lo});
    if (mf_during) begin
      chk({tag, "_mfhi"}, {32'd0, result_out}, {32'd0, exp_hi});
      valid_in = 1'b0;
      op_in    = 3'd0;
    end
  endtask

  initial begin
    int ndone;
    rst_n    = 1'b0;
    valid_in = 1'b0;
    op_in    = 3'd0;
    mt_lo_in = 1'b0;
    a_in     = '0;
    b_in     = '0;
    abort_in = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_stall", {63'd0, stall_out}, 64'd0);
    chk("rst_done", {63'd0, done_out}, 64'd0);
    chk("rst_hi", {32'd0, hi_out}, 64'd0);
    chk("rst_lo", {32'd0, lo_out}, 64'd0);
    valid_in = 1'b1;
    op_in    = 3'd1;
    #1;
    chk("rst_issue_stall", {63'd0, stall_out}, 64'd0);
    op_in = 3'd5;
    #1;
    chk("rst_result", {32'd0, result_out}, 64'd0);
    valid_in = 1'b0;
    op_in    = 3'd0;
    step();
    rst_n = 1'b1;
    step();

    run_op(3'd1, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, "mult_neg");
    step();
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu_max");
    step();
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_neg7");
    step();
    run_op(3'd4, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF, 1'b0, "divu_zero");
    step();
    run_op(3'd3, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0, "div_zero");
    step();
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, "div_ovf");
    step();

    // MTLO then MFLO the next cycle
    valid_in = 1'b1;
    op_in    = 3'd7;
    mt_lo_in = 1'b1;
    a_in     = 32'h1234_5678;
    #1;
    chk("mtlo_stall", {63'd0, stall_out}, 64'd0);
    step();
    op_in = 3'd6;
    a_in  = '0;
    #1;
    chk("mflo_result", {32'd0, result_out}, 64'h1234_5678);
    chk("mflo_stall", {63'd0, stall_out}, 64'd0);
    valid_in = 1'b0;
    op_in    = 3'd0;
    step();

    run_op(3'd4, 32'd9, 32'd4, 32'd1, 32'd2, 1'b1, "divu_mfhi");
    step();

    // Preload HI/LO, then abort a MULT in CALC
    valid_in = 1'b1;
    op_in    = 3'd7;
    mt_lo_in = 1'b0;
    a_in     = 32'hA;
    step();
    mt_lo_in = 1'b1;
    a_in     = 32'hB;
    step();
    valid_in = 1'b0;
    op_in    = 3'd0;
    #1;
    chk("mt_hi", {32'd0, hi_out}, 64'hA);
    chk("mt_lo", {32'd0, lo_out}, 64'hB);
    step();
    ndone    = 0;
    valid_in = 1'b1;
    op_in    = 3'd1;
    a_in     = 32'd5;
    b_in     = 32'd7;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (done_out === 1'b1) ndone++;
      step();
    end
    abort_in = 1'b1;
    #1;
    chk("abort_calc_stall", {63'd0, stall_out}, 64'd1);
    step();
    abort_in = 1'b0;
    valid_in = 1'b0;
    op_in    = 3'd0;
    #1;
    chk("abort_stall", {63'd0, stall_out}, 64'd0);
    chk("abort_hi", {32'd0, hi_out}, 64'hA);
    chk("abort_lo", {32'd0, lo_out}, 64'hB);
    for (int k = 0; k < 30; k++) begin
      step();
      if (done_out === 1'b1) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'd0);
    chk("abort_hi_late", {32'd0, hi_out}, 64'hA);
    chk("abort_lo_late", {32'd0, lo_out}, 64'hB);

    // Abort in IDLE beats an issuing op
    step();
    valid_in = 1'b1;
    op_in    = 3'd4;
    a_in     = 32'd9;
    b_in     = 32'd4;
    abort_in = 1'b1;
    #1;
    chk("abort_idle_stall", {63'd0, stall_out}, 64'd0);
    step();
    valid_in = 1'b0;
    op_in    = 3'd0;
    abort_in = 1'b0;
    #1;
    chk("abort_idle_nostart", {63'd0, stall_out}, 64'd0);

    // Reset in the middle of a DIV
    step();
    valid_in = 1'b1;
    op_in    = 3'd3;
    a_in     = 32'd100;
    b_in     = 32'd7;
    for (int k = 0; k < 20; k++) step();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_stall", {63'd0, stall_out}, 64'd0);
    chk("rst_mid_hi", {32'd0, hi_out}, 64'd0);
    chk("rst_mid_lo", {32'd0, lo_out}, 64'd0);
    chk("rst_mid_done", {63'd0, done_out}, 64'd0);
    valid_in = 1'b0;
    op_in    = 3'd0;
    step();
    rst_n = 1'b1;
    step();
    run_op(3'd2, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, "multu_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
